// File: rtl/cpu24_pkg.sv
// Shared cpu24 constants and the result-readout state encoding.
// Contents: data/address widths, result block location and size,
// readout FSM state enum.
package cpu24_pkg;

    localparam int unsigned DATA_W       = 24;
    localparam int unsigned DMEM_ADDR_W  = 12;
    localparam logic [DMEM_ADDR_W-1:0] RESULT_BASE = 12'h300;
    localparam int unsigned RESULT_WORDS = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_SEND,
        ST_TAIL,
        ST_DONE
    } readout_state_e;

endpackage

// File: rtl/word_byte_tx.sv
// Serialises one 24-bit word as 3 bytes MSB-first on a valid/ready link,
// or a single byte (low byte of word_i) in one-byte load mode.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   load_i             load word_i and start sending (takes priority)
//   load_one_i         with load_i: send only word_i[7:0]
//   word_i             word to send
//   tx_ready_i         sink ready
//   tx_data_o          current byte (stable while not accepted)
//   tx_valid_o         byte valid
//   last_accepted_c_o  combinational: final byte of the load accepted this cycle
module word_byte_tx
    import cpu24_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              load_one_i,
    input  logic [DATA_W-1:0] word_i,
    input  logic              tx_ready_i,
    output logic [7:0]        tx_data_o,
    output logic              tx_valid_o,
    output logic              last_accepted_c_o
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 2;

    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  left_q, left_d;   // bytes remaining after the current one
    logic              valid_q, valid_d;
    logic              accept;

    assign accept            = valid_q & tx_ready_i;
    assign last_accepted_c_o = accept && (left_q == CNT_W'(0));
    assign tx_data_o         = shift_q[DATA_W-1 -: BYTE_W];
    assign tx_valid_o        = valid_q;

    // Next-state: load wins over acceptance, shift left one byte per accept.
    always_comb begin
        shift_d = shift_q;
        left_d  = left_q;
        valid_d = valid_q;
        if (load_i) begin
            valid_d = 1'b1;
            if (load_one_i) begin
                shift_d = {word_i[BYTE_W-1:0], (DATA_W-BYTE_W)'(0)};
                left_d  = CNT_W'(0);
            end else begin
                shift_d = word_i;
                left_d  = CNT_W'(2);
            end
        end else if (accept) begin
            if (left_q == CNT_W'(0)) begin
                valid_d = 1'b0;
            end else begin
                shift_d = {shift_q[DATA_W-BYTE_W-1:0], BYTE_W'(0)};
                left_d  = left_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            left_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            left_q  <= left_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/halt_result_readout.sv
// On a rising CPU halt, reads NUM_WORDS result words from data memory at
// BASE_ADDR, streams them as bytes MSB-first, then one byte holding the
// index of the largest signed word (lowest index wins ties).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   halt            CPU halt flag (rising edge starts a readout from IDLE)
//   mem_re/mem_addr data memory read request
//   mem_rdata       read data, valid the cycle after mem_re
//   tx_data/tx_valid/tx_ready  byte stream
//   busy            readout in progress
//   done            readout complete, held until halt falls
//   argmax          index of the largest signed word
module halt_result_readout #(
    parameter int unsigned DATA_W    = cpu24_pkg::DATA_W,
    parameter int unsigned ADDR_W    = cpu24_pkg::DMEM_ADDR_W,
    parameter logic [ADDR_W-1:0] BASE_ADDR = cpu24_pkg::RESULT_BASE,
    parameter int unsigned NUM_WORDS = cpu24_pkg::RESULT_WORDS,
    parameter int unsigned IDX_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done,
    output logic [IDX_W-1:0]  argmax
);

    import cpu24_pkg::*;

    localparam int unsigned LAST_IDX = NUM_WORDS - 1;

    readout_state_e    state_q, state_d;
    logic              halt_q;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] max_q;
    logic [IDX_W-1:0]  argmax_q;
    logic              mem_re_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              busy_q, done_q;

    logic              trigger, last_word, new_max;
    logic              ld, ld_one, last_acc;
    logic [DATA_W-1:0] ld_word;

    assign trigger   = halt & ~halt_q;
    assign last_word = (idx_q == IDX_W'(LAST_IDX));
    // Word 0 always seeds the maximum; later words replace it only if strictly greater.
    assign new_max   = (idx_q == '0) || ($signed(mem_rdata) > $signed(max_q));

    word_byte_tx u_tx (
        .clk               (clk),
        .rst               (rst),
        .load_i            (ld),
        .load_one_i        (ld_one),
        .word_i            (ld_word),
        .tx_ready_i        (tx_ready),
        .tx_data_o         (tx_data),
        .tx_valid_o        (tx_valid),
        .last_accepted_c_o (last_acc)
    );

    // Next-state and serializer load control.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ld      = 1'b0;
        ld_one  = 1'b0;
        ld_word = mem_rdata;
        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    state_d = ST_REQ;
                    idx_d   = '0;
                end
            end
            ST_REQ:  state_d = ST_WAIT;
            ST_WAIT: begin
                ld      = 1'b1;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (last_acc) begin
                    if (last_word) begin
                        // Tail byte is loaded in the same edge the last data byte leaves.
                        ld      = 1'b1;
                        ld_one  = 1'b1;
                        ld_word = DATA_W'(argmax_q);
                        state_d = ST_TAIL;
                    end else begin
                        idx_d   = IDX_W'(idx_q + IDX_W'(1));
                        state_d = ST_REQ;
                    end
                end
            end
            ST_TAIL: begin
                if (last_acc) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (!halt) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Registered outputs derived from the next state, plus argmax tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            halt_q     <= 1'b0;
            idx_q      <= '0;
            max_q      <= '0;
            argmax_q   <= '0;
            mem_re_q   <= 1'b0;
            mem_addr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            halt_q   <= halt;
            idx_q    <= idx_d;
            mem_re_q <= (state_d == ST_REQ);
            busy_q   <= (state_d inside {ST_REQ, ST_WAIT, ST_SEND, ST_TAIL});
            done_q   <= (state_d == ST_DONE);
            if (state_d == ST_REQ) begin
                // Wraps modulo 2^ADDR_W by design.
                mem_addr_q <= BASE_ADDR + ADDR_W'(idx_d);
            end
            if (state_q == ST_IDLE && trigger) begin
                max_q <= '0;
            end else if (state_q == ST_WAIT && new_max) begin
                max_q    <= mem_rdata;
                argmax_q <= idx_q;
            end
        end
    end

    assign mem_re   = mem_re_q;
    assign mem_addr = mem_addr_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign argmax   = argmax_q;

endmodule
